// File: rtl/ir_receiver_decoder.sv
// IR remote packet decoder: start burst, car-select burst, then four data bursts
// whose carrier-pulse counts encode command bits LSB first.
//
// state  | meaning
// IDLE   | waiting for a start burst
// SELECT | start seen, next burst is the car-select length
// BITS   | collecting four data bursts, bit_idx selects the target bit
// DONE   | one-cycle command-valid strobe
module ir_receiver_decoder #(
    parameter int START_SIZE    = 191,
    parameter int ASSERT_SIZE   = 47,
    parameter int DEASSERT_SIZE = 22,
    parameter int TOL           = 4,
    parameter int GAP_CYCLES    = 6000,
    parameter int PKT_TIMEOUT   = 2000000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       IR_IN,
    output logic [3:0] COMMAND,
    output logic [7:0] SELECT_LEN,
    output logic       CMD_VALID,
    output logic       RX_ERROR,
    output logic       BUSY
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_BITS   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [31:0] GAP_W = 32'(GAP_CYCLES);
    localparam logic [31:0] PKT_W = 32'(PKT_TIMEOUT);

    logic        ir_s1_q, ir_s1_d;
    logic        ir_s2_q, ir_s2_d;
    logic        ir_prev_q, ir_prev_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic [31:0] pkt_tmr_q, pkt_tmr_d;
    logic [1:0]  state_q, state_d;
    logic [1:0]  bit_idx_q, bit_idx_d;
    logic [3:0]  stage_cmd_q, stage_cmd_d;
    logic [7:0]  stage_sel_q, stage_sel_d;
    logic [3:0]  command_q, command_d;
    logic [7:0]  select_len_q, select_len_d;
    logic        rx_error_q, rx_error_d;

    logic        carrier_edge;
    logic        burst_end;
    logic        pkt_timeout;
    logic [7:0]  burst_base;
    logic [31:0] len_w;
    logic        is_start, is_one, is_zero;
    logic [3:0]  new_cmd;

    function automatic logic in_window(input logic [31:0] len, input int target);
        return (len + 32'(TOL) >= 32'(target)) && (len <= 32'(target + TOL));
    endfunction

    assign carrier_edge = ir_s2_q & ~ir_prev_q;
    assign burst_end    = (idle_cnt_q == GAP_W) && (burst_cnt_q != 8'd0);
    assign pkt_timeout  = (pkt_tmr_q == PKT_W);
    assign len_w        = {24'd0, burst_cnt_q};
    assign is_start     = in_window(len_w, START_SIZE);
    assign is_one       = in_window(len_w, ASSERT_SIZE);
    assign is_zero      = in_window(len_w, DEASSERT_SIZE);

    // Counters: an edge coinciding with burst_end starts the next burst at 1.
    always_comb begin
        ir_s1_d   = IR_IN;
        ir_s2_d   = ir_s1_q;
        ir_prev_d = ir_s2_q;

        burst_base  = burst_end ? 8'd0 : burst_cnt_q;
        burst_cnt_d = burst_base;
        if (carrier_edge && burst_base != 8'hff) begin
            burst_cnt_d = burst_base + 8'd1;
        end

        if (carrier_edge) begin
            idle_cnt_d = 32'd0;
        end else if (idle_cnt_q == GAP_W) begin
            idle_cnt_d = idle_cnt_q;
        end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end

        if ((state_q == S_SELECT || state_q == S_BITS) && !burst_end) begin
            pkt_tmr_d = pkt_tmr_q + 32'd1;
        end else begin
            pkt_tmr_d = 32'd0;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        stage_cmd_d  = stage_cmd_q;
        stage_sel_d  = stage_sel_q;
        command_d    = command_q;
        select_len_d = select_len_q;
        rx_error_d   = 1'b0;
        new_cmd      = stage_cmd_q;
        new_cmd[bit_idx_q] = is_one;

        case (state_q)
            S_IDLE: begin
                if (burst_end && is_start) begin
                    state_d   = S_SELECT;
                    bit_idx_d = 2'd0;
                end
            end
            S_SELECT: begin
                if (burst_end) begin
                    bit_idx_d = 2'd0;
                    if (!is_start) begin
                        stage_sel_d = burst_cnt_q;
                        state_d     = S_BITS;
                    end
                end else if (pkt_timeout) begin
                    state_d    = S_IDLE;
                    rx_error_d = 1'b1;
                end
            end
            S_BITS: begin
                if (burst_end) begin
                    if (is_start) begin
                        state_d   = S_SELECT;
                        bit_idx_d = 2'd0;
                    end else if (is_one || is_zero) begin
                        stage_cmd_d = new_cmd;
                        if (bit_idx_q == 2'd3) begin
                            // Outputs load on entry so they are already valid in DONE.
                            state_d      = S_DONE;
                            command_d    = new_cmd;
                            select_len_d = stage_sel_q;
                        end else begin
                            bit_idx_d = bit_idx_q + 2'd1;
                        end
                    end else begin
                        state_d    = S_IDLE;
                        rx_error_d = 1'b1;
                    end
                end else if (pkt_timeout) begin
                    state_d    = S_IDLE;
                    rx_error_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ir_s1_q      <= 1'b0;
            ir_s2_q      <= 1'b0;
            ir_prev_q    <= 1'b0;
            burst_cnt_q  <= 8'd0;
            idle_cnt_q   <= 32'd0;
            pkt_tmr_q    <= 32'd0;
            state_q      <= S_IDLE;
            bit_idx_q    <= 2'd0;
            stage_cmd_q  <= 4'd0;
            stage_sel_q  <= 8'd0;
            command_q    <= 4'd0;
            select_len_q <= 8'd0;
            rx_error_q   <= 1'b0;
        end else begin
            ir_s1_q      <= ir_s1_d;
            ir_s2_q      <= ir_s2_d;
            ir_prev_q    <= ir_prev_d;
            burst_cnt_q  <= burst_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            pkt_tmr_q    <= pkt_tmr_d;
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            stage_cmd_q  <= stage_cmd_d;
            stage_sel_q  <= stage_sel_d;
            command_q    <= command_d;
            select_len_q <= select_len_d;
            rx_error_q   <= rx_error_d;
        end
    end

    assign COMMAND    = command_q;
    assign SELECT_LEN = select_len_q;
    assign CMD_VALID  = (state_q == S_DONE);
    assign RX_ERROR   = rx_error_q;
    assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_receiver_decoder.sv
// Scoreboard bench for ir_receiver_decoder: stimulus pushes expected strobes,
// a negedge monitor pops and compares them as CMD_VALID / RX_ERROR appear.
module tb_ir_receiver_decoder;

    localparam int GAP = 16;
    localparam int PKT = 2000;

    logic       clk;
    logic       rst_n;
    logic       ir_in;
    logic [3:0] command;
    logic [7:0] select_len;
    logic       cmd_valid;
    logic       rx_error;
    logic       busy;

    typedef struct {
        bit         is_err;
        logic [3:0] cmd;
        logic [7:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    ir_receiver_decoder #(
        .START_SIZE(191), .ASSERT_SIZE(47), .DEASSERT_SIZE(22), .TOL(4),
        .GAP_CYCLES(GAP), .PKT_TIMEOUT(PKT)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .IR_IN(ir_in), .COMMAND(command),
        .SELECT_LEN(select_len), .CMD_VALID(cmd_valid), .RX_ERROR(rx_error),
        .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (cmd_valid && rx_error) begin
            check("strobe_overlap", 32'd1, 32'd0);
        end else if (cmd_valid || rx_error) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, cmd_valid, rx_error}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind", {31'd0, rx_error}, {31'd0, e.is_err});
                if (!e.is_err) begin
                    check("command", {28'd0, command}, {28'd0, e.cmd});
                    check("select_len", {24'd0, select_len}, {24'd0, e.sel});
                end
            end
        end
    end

    task automatic expect_cmd(input logic [3:0] c, input logic [7:0] s);
        exp_t e;
        e.is_err = 1'b0; e.cmd = c; e.sel = s;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1; e.cmd = 4'd0; e.sel = 8'd0;
        exp_q.push_back(e);
    endtask

    // Each carrier pulse: 2 cycles high, 2 low; bursts are followed by a 25-pulse gap.
    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ir_in = 1'b1;
            @(negedge clk);
            @(negedge clk) ir_in = 1'b0;
            @(negedge clk);
        end
        repeat (4 * 25) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_command"}, {28'd0, command}, 32'd0);
        check({tag, "_select_len"}, {24'd0, select_len}, 32'd0);
        check({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
        check({tag, "_rx_error"}, {31'd0, rx_error}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        ir_in = 1'b0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic packet: data bits LSB first 1,0,1,0.
        expect_cmd(4'b0101, 8'd47);
        burst(191);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        burst(47); burst(47); burst(22); burst(47); burst(22);
        check("busy_after_pkt", {31'd0, busy}, 32'd0);

        // Bad data burst aborts; previous outputs stay.
        expect_err();
        burst(191); burst(47); burst(35);
        check("abort_command_kept", {28'd0, command}, 32'h5);
        check("abort_sel_kept", {24'd0, select_len}, 32'd47);
        check("abort_busy", {31'd0, busy}, 32'd0);

        // Restart mid-packet.
        expect_cmd(4'b1000, 8'd24);
        burst(191); burst(47); burst(47);
        burst(191); burst(24); burst(22); burst(22); burst(22); burst(47);

        // Start tolerance edges; 186 is outside the window and ignored in IDLE.
        expect_cmd(4'b1111, 8'd30);
        burst(188); burst(30); burst(47); burst(47); burst(47); burst(47);
        expect_cmd(4'b0000, 8'd50);
        burst(195); burst(50); burst(22); burst(22); burst(22); burst(22);
        burst(186);
        check("ignored_186_busy", {31'd0, busy}, 32'd0);
        burst(47);
        check("ignored_data_busy", {31'd0, busy}, 32'd0);

        // Packet timeout.
        expect_err();
        burst(191); burst(47);
        check("timeout_pre_busy", {31'd0, busy}, 32'd1);
        repeat (PKT + 50) @(negedge clk);
        check("timeout_busy", {31'd0, busy}, 32'd0);

        // Reset mid-packet discards it silently.
        burst(191); burst(47); burst(47); burst(22); burst(47);
        check("midpkt_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midpkt_reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        expect_cmd(4'b0111, 8'd100);
        burst(191); burst(100); burst(47); burst(47); burst(47); burst(22);

        waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_receiver_decoder.md
IR_RECEIVER_DECODER -- requirements
Module: ir_receiver_decoder

Interface
REQ-001 SHALL have parameter START_SIZE, default 191, start-burst length in carrier pulses.
REQ-002 SHALL have parameter ASSERT_SIZE, default 47, carrier-pulse length of a burst encoding a command bit of 1.
REQ-003 SHALL have parameter DEASSERT_SIZE, default 22, carrier-pulse length of a burst encoding a command bit of 0.
REQ-004 SHALL have parameter TOL, default 4, accepted ± pulse-count tolerance for every burst classification.
REQ-005 SHALL have parameter GAP_CYCLES, default 6000, count of CLK cycles without a carrier rising edge that ends a burst.
REQ-006 SHALL have parameter PKT_TIMEOUT, default 2000000, count of CLK cycles without a burst end that aborts a packet in progress.
REQ-007 SHALL have port CLK, input, 1, the system clock; it is the only clock.
REQ-008 SHALL have port RESET_N, input, 1, a synchronous active-low reset.
REQ-009 SHALL have port IR_IN, input, 1, the raw modulated IR receiver signal, asynchronous to CLK.
REQ-010 SHALL have port COMMAND, output, 4, the last successfully decoded command.
REQ-011 SHALL have port SELECT_LEN, output, 8, the measured car-select burst length of the last good packet.
REQ-012 SHALL have port CMD_VALID, output, 1, a one-cycle pulse when COMMAND and SELECT_LEN update.
REQ-013 SHALL have port RX_ERROR, output, 1, a one-cycle pulse when a packet is aborted.
REQ-014 SHALL have port BUSY, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL pass IR_IN through a 2-flop synchroniser; a carrier edge is a rising edge detected on the synchronised signal (0 then 1 across consecutive CLK cycles).
REQ-016 SHALL count carrier edges into an 8-bit burst counter that saturates at 255.
REQ-017 SHALL count CLK cycles since the last carrier edge; this counter resets to 0 on every edge.
REQ-018 SHALL raise a one-cycle burst_end in the cycle where the idle counter reaches GAP_CYCLES while the burst counter is nonzero; it latches length L and clears the burst counter in that same cycle.
REQ-019 SHALL classify L as follows: START if |L-START_SIZE|<=TOL; ONE if |L-ASSERT_SIZE|<=TOL; ZERO if |L-DEASSERT_SIZE|<=TOL; otherwise BAD. START takes priority over the other classes.
REQ-020 SHALL use FSM states IDLE, SELECT, BITS and DONE, with a 2-bit bit index.
REQ-021 In IDLE, a START burst SHALL move the FSM to SELECT; any other burst SHALL be ignored with no RX_ERROR.
REQ-022 In SELECT, any non-START burst SHALL capture L into a staging register and move the FSM to BITS with index 0.
REQ-023 In BITS, a ONE or ZERO burst SHALL write staging bit[index] (1 or 0); the first data burst maps to bit 0 and the fourth to bit 3.
REQ-024 In BITS, after the burst at index 3 the FSM SHALL move to DONE; otherwise the index SHALL increment.
REQ-025 DONE SHALL last one cycle: COMMAND and SELECT_LEN load from staging, CMD_VALID=1, then the FSM returns to IDLE.
REQ-026 A BAD burst in BITS SHALL abort the packet: FSM to IDLE, RX_ERROR pulse, COMMAND and SELECT_LEN unchanged.
REQ-027 A START burst in SELECT or BITS SHALL restart the packet: FSM to SELECT, index cleared, no RX_ERROR.
REQ-028 In SELECT or BITS, a packet timer reaching PKT_TIMEOUT SHALL abort with FSM to IDLE and an RX_ERROR pulse; the timer clears on each burst_end and in IDLE.
REQ-029 If burst_end and the packet timeout occur in the same cycle, burst_end SHALL win.
REQ-030 CMD_VALID and RX_ERROR SHALL never be asserted in the same cycle.
REQ-031 Output latency SHALL be exactly 1 CLK cycle from the final burst_end to CMD_VALID.

Reset
REQ-032 While RESET_N=0 at a CLK edge, the block SHALL set FSM=IDLE; COMMAND=0; SELECT_LEN=0; CMD_VALID, RX_ERROR and BUSY=0; and clear all counters and synchroniser flops.
REQ-033 A reset asserted mid-packet SHALL discard the packet with no CMD_VALID and no RX_ERROR.

Verification
REQ-034 Bench SHALL send packet bursts 191,47,47,22,47,22 with 25-pulse gaps -> one CMD_VALID; COMMAND=4'b0101; SELECT_LEN=47.
REQ-035 Bench SHALL send bursts 191,47 then a 35-pulse data burst -> RX_ERROR pulse; COMMAND unchanged; BUSY=0.
REQ-036 Bench SHALL send bursts 191,47,47 then a new 191,24,22,22,22,47 -> single CMD_VALID; COMMAND=4'b1000; SELECT_LEN=24.
REQ-037 Bench SHALL send bursts 188 and 195 as start (within TOL) and 186 -> 188 and 195 are accepted; 186 is ignored in IDLE.
REQ-038 Bench SHALL send bursts 191,47 then silence for PKT_TIMEOUT cycles -> RX_ERROR exactly once; FSM=IDLE.
REQ-039 Bench SHALL drive RESET_N low after the third data burst -> no output pulses; outputs read 0; a following full packet decodes correctly.
